// File: rtl/reg_file_sb_pkg.sv
// Shared types and constants for the multi-port register file
// with pending-write scoreboard.
package reg_file_sb_pkg;

    localparam int REG_ZERO  = 0;
    localparam int RF_XLEN   = 32;
    localparam int RF_AW_MAX = 8;

    // Write-back bus in its widest form; DATA_WIDTH must not exceed RF_XLEN
    typedef struct packed {
        logic                 en;
        logic [RF_AW_MAX-1:0] addr;
        logic [RF_XLEN-1:0]   data;
    } wr_port_t;

    function automatic int rf_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode-side bus of the register file: reads, two write-backs,
// issue notification and pending count.
interface reg_file_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic                         wr0_en;
    logic [ADDR_WIDTH-1:0]        wr0_addr;
    logic [DATA_WIDTH-1:0]        wr0_data;
    logic                         wr1_en;
    logic [ADDR_WIDTH-1:0]        wr1_addr;
    logic [DATA_WIDTH-1:0]        wr1_data;
    logic                         iss_en;
    logic [ADDR_WIDTH-1:0]        iss_addr;
    logic [ADDR_WIDTH:0]          pend_cnt;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
        input  rd_data, rd_busy, pend_cnt
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
        output rd_data, rd_busy, pend_cnt
    );
endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: zero register, write-back bypass
// and busy lookup with same-cycle write clear.
module rf_read_port
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int DEPTH      = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] arr_data,
    input  logic [DEPTH-1:0]      busy,
    input  wr_port_t              wp0,
    input  wr_port_t              wp1,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  busy_o
);
    localparam bit ZR = (ZERO_REG != 0);

    logic is_zero;
    logic hit0;
    logic hit1;

    assign is_zero = ZR && (addr == ADDR_WIDTH'(REG_ZERO));
    assign hit0    = wp0.en && (wp0.addr == RF_AW_MAX'(addr));
    assign hit1    = wp1.en && (wp1.addr == RF_AW_MAX'(addr));

    // Several conditions can hold at once; order sets precedence
    always_comb begin
        data = arr_data;
        priority case (1'b1)
            is_zero: data = '0;
            hit1:    data = DATA_WIDTH'(wp1.data);
            hit0:    data = DATA_WIDTH'(wp0.data);
            default: data = arr_data;
        endcase
    end

    assign busy_o = busy[addr] && !hit0 && !hit1 && !is_zero;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with two prioritised write-backs, bypassed
// reads and a per-register pending-producer scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = rf_depth(ADDR_WIDTH);
    localparam int CW    = ADDR_WIDTH + 1;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [CW-1:0]         pend_q;
    wr_port_t              wp0;
    logic                  wr0_ok;
    logic                  wr1_ok;
    wr_port_t              wp1;
    logic                  iss_ok;
    logic                  rise;
    logic                  fall0;
    logic                  fall1;

    assign wp0 = '{en:   bus.wr0_en,
                   addr: RF_AW_MAX'(bus.wr0_addr),
                   data: RF_XLEN'(bus.wr0_data)};
    assign wp1 = '{en:   bus.wr1_en,
                   addr: RF_AW_MAX'(bus.wr1_addr),
                   data: RF_XLEN'(bus.wr1_data)};

    assign wr0_ok = wp0.en && !(ZR && bus.wr0_addr == ADDR_WIDTH'(REG_ZERO));
    assign wr1_ok = wp1.en && !(ZR && bus.wr1_addr == ADDR_WIDTH'(REG_ZERO));
    assign iss_ok = bus.iss_en && !(ZR && bus.iss_addr == ADDR_WIDTH'(REG_ZERO));

    // Counter moves only on real busy transitions; an issue wins over a clear
    assign rise  = iss_ok && !busy[bus.iss_addr];
    assign fall0 = wr0_ok && busy[bus.wr0_addr]
                   && !(iss_ok && bus.iss_addr == bus.wr0_addr);
    assign fall1 = wr1_ok && busy[bus.wr1_addr]
                   && !(iss_ok && bus.iss_addr == bus.wr1_addr)
                   && !(wr0_ok && bus.wr0_addr == bus.wr1_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr0_ok) mem[bus.wr0_addr] <= bus.wr0_data;
            if (wr1_ok) mem[bus.wr1_addr] <= bus.wr1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            pend_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (iss_ok && bus.iss_addr == ADDR_WIDTH'(i))
                    busy[i] <= 1'b1;
                else if ((wr0_ok && bus.wr0_addr == ADDR_WIDTH'(i)) ||
                         (wr1_ok && bus.wr1_addr == ADDR_WIDTH'(i)))
                    busy[i] <= 1'b0;
            end
            pend_q <= pend_q + CW'(rise) - CW'(fall0) - CW'(fall1);
        end
    end

    assign bus.pend_cnt = pend_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        assign addr = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        rf_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ZERO_REG   (ZERO_REG),
            .DEPTH      (DEPTH)
        ) u_rd (
            .addr     (addr),
            .arr_data (mem[addr]),
            .busy     (busy),
            .wp0      (wp0),
            .wp1      (wp1),
            .data     (bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .busy_o   (bus.rd_busy[k])
        );
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed plus randomized bench for reg_file_sb: default build checked
// against a behavioural model, and a 4-port / no-zero-register build.
module tb_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    reg_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) a ();
    reg_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD(4)) b ();

    reg_file_sb #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .ZERO_REG(1)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a)
    );

    reg_file_sb #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD(4), .ZERO_REG(0)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state for dut_a: register values and outstanding producers
    logic [31:0] mm [32];
    logic        mb [32];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int ad);
        if (ad == 0) return 32'h0;
        if (a.wr1_en && int'(a.wr1_addr) == ad) return a.wr1_data;
        if (a.wr0_en && int'(a.wr0_addr) == ad) return a.wr0_data;
        return mm[ad];
    endfunction

    function automatic logic exp_busy(input int ad);
        if (ad == 0) return 1'b0;
        if (a.wr1_en && int'(a.wr1_addr) == ad) return 1'b0;
        if (a.wr0_en && int'(a.wr0_addr) == ad) return 1'b0;
        return mb[ad];
    endfunction

    function automatic int pop();
        int s = 0;
        for (int i = 0; i < 32; i++) s += int'(mb[i]);
        return s;
    endfunction

    task automatic check_a(input string tag);
        int ad;
        for (int k = 0; k < 2; k++) begin
            ad = int'(a.rd_addr[k*5 +: 5]);
            chk({tag, "/data"}, a.rd_data[k*32 +: 32], exp_data(ad));
            chk({tag, "/busy"}, 32'(a.rd_busy[k]), 32'(exp_busy(ad)));
        end
        chk({tag, "/pend"}, 32'(a.pend_cnt), 32'(pop()));
    endtask

    // Advance one clock and apply the architectural update to the model
    task automatic tick();
        @(posedge clk);
        if (rst_a) begin
            for (int i = 0; i < 32; i++) begin
                mm[i] = 32'h0;
                mb[i] = 1'b0;
            end
        end else begin
            if (a.wr0_en && a.wr0_addr != 5'd0) mm[a.wr0_addr] = a.wr0_data;
            if (a.wr1_en && a.wr1_addr != 5'd0) mm[a.wr1_addr] = a.wr1_data;
            if (a.wr0_en) mb[a.wr0_addr] = 1'b0;
            if (a.wr1_en) mb[a.wr1_addr] = 1'b0;
            if (a.iss_en && a.iss_addr != 5'd0) mb[a.iss_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle_a();
        a.wr0_en = 1'b0; a.wr0_addr = '0; a.wr0_data = '0;
        a.wr1_en = 1'b0; a.wr1_addr = '0; a.wr1_data = '0;
        a.iss_en = 1'b0; a.iss_addr = '0;
    endtask

    task automatic idle_b();
        b.wr0_en = 1'b0; b.wr0_addr = '0; b.wr0_data = '0;
        b.wr1_en = 1'b0; b.wr1_addr = '0; b.wr1_data = '0;
        b.iss_en = 1'b0; b.iss_addr = '0; b.rd_addr = '0;
    endtask

    function automatic logic [4:0] ra();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            mm[i] = 32'h0;
            mb[i] = 1'b0;
        end
        idle_a();
        idle_b();
        a.rd_addr = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);

        // Reset discards concurrent writes, x0 is hard zero
        a.wr0_en = 1'b1; a.wr0_addr = 5'd0; a.wr0_data = 32'hDEADBEEF;
        a.wr1_en = 1'b1; a.wr1_addr = 5'd5; a.wr1_data = 32'hDEADBEEF;
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle_a();
        a.rd_addr = {5'd5, 5'd0};
        #1;
        chk("rst_x0", a.rd_data[31:0], 32'h0);
        chk("rst_x5", a.rd_data[63:32], 32'h0);
        chk("rst_busy", 32'(a.rd_busy), 32'h0);
        chk("rst_pend", 32'(a.pend_cnt), 32'h0);

        // Dual write to one register: port 1 wins, bypassed same cycle
        a.wr0_en = 1'b1; a.wr0_addr = 5'd7; a.wr0_data = 32'h11;
        tick();
        idle_a();
        a.wr0_en = 1'b1; a.wr0_addr = 5'd7; a.wr0_data = 32'h22;
        a.wr1_en = 1'b1; a.wr1_addr = 5'd7; a.wr1_data = 32'h33;
        a.rd_addr = {5'd7, 5'd7};
        #1;
        chk("byp_same", a.rd_data[31:0], 32'h33);
        tick();
        idle_a();
        #1;
        chk("byp_array", a.rd_data[63:32], 32'h33);

        // Busy lifecycle of x3
        a.iss_en = 1'b1; a.iss_addr = 5'd3;
        a.rd_addr = {5'd3, 5'd3};
        #1;
        chk("sb_iss_hidden", 32'(a.rd_busy[0]), 32'h0);
        tick();
        idle_a();
        #1;
        chk("sb_busy", 32'(a.rd_busy[0]), 32'h1);
        chk("sb_pend1", 32'(a.pend_cnt), 32'h1);
        tick();
        a.wr0_en = 1'b1; a.wr0_addr = 5'd3; a.wr0_data = 32'h77;
        #1;
        chk("sb_wr_clear", 32'(a.rd_busy[1]), 32'h0);
        chk("sb_pend_hold", 32'(a.pend_cnt), 32'h1);
        tick();
        idle_a();
        #1;
        chk("sb_pend0", 32'(a.pend_cnt), 32'h0);

        // Issue and write to busy x9 in one cycle: issue wins
        a.iss_en = 1'b1; a.iss_addr = 5'd9;
        tick();
        a.wr0_en = 1'b1; a.wr0_addr = 5'd9; a.wr0_data = 32'h5;
        tick();
        idle_a();
        a.rd_addr = {5'd0, 5'd9};
        #1;
        chk("soc_busy", 32'(a.rd_busy[0]), 32'h1);
        chk("soc_data", a.rd_data[31:0], 32'h5);
        chk("soc_pend", 32'(a.pend_cnt), 32'h1);
        a.wr1_en = 1'b1; a.wr1_addr = 5'd9; a.wr1_data = 32'h6;
        tick();
        idle_a();

        // Fill the scoreboard, dual clear, then reset
        for (int r = 1; r < 32; r++) begin
            a.iss_en = 1'b1; a.iss_addr = 5'(r);
            tick();
        end
        idle_a();
        a.iss_en = 1'b1; a.iss_addr = 5'd0;
        #1;
        chk("cnt_full", 32'(a.pend_cnt), 32'd31);
        tick();
        idle_a();
        #1;
        chk("cnt_iss_x0", 32'(a.pend_cnt), 32'd31);
        a.wr0_en = 1'b1; a.wr0_addr = 5'd1; a.wr0_data = 32'h1234;
        a.wr1_en = 1'b1; a.wr1_addr = 5'd2; a.wr1_data = 32'h5678;
        tick();
        idle_a();
        a.rd_addr = {5'd2, 5'd1};
        #1;
        chk("cnt_dual", 32'(a.pend_cnt), 32'd29);
        chk("cnt_x1", a.rd_data[31:0], 32'h1234);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        #1;
        chk("cnt_rst", 32'(a.pend_cnt), 32'd0);
        chk("cnt_rst_x2", a.rd_data[63:32], 32'h0);

        // Random traffic checked every cycle against the model
        for (int c = 0; c < 400; c++) begin
            a.wr0_en   = 1'($urandom_range(0, 1));
            a.wr0_addr = ra();
            a.wr0_data = $urandom;
            a.wr1_en   = 1'($urandom_range(0, 1));
            a.wr1_addr = ra();
            a.wr1_data = $urandom;
            a.iss_en   = 1'($urandom_range(0, 1));
            a.iss_addr = ra();
            a.rd_addr  = {ra(), ra()};
            rst_a      = ($urandom_range(0, 99) == 0);
            #1;
            check_a("rand");
            tick();
        end
        rst_a = 1'b0;
        idle_a();

        // Four ports, 16 registers, x0 is an ordinary register
        b.wr0_en = 1'b1; b.wr0_addr = 4'd0; b.wr0_data = 32'hA;
        tick();
        idle_b();
        #1;
        for (int k = 0; k < 4; k++)
            chk("b_rd_x0", b.rd_data[k*32 +: 32], 32'hA);
        b.iss_en = 1'b1; b.iss_addr = 4'd0;
        tick();
        idle_b();
        #1;
        for (int k = 0; k < 4; k++)
            chk("b_busy_x0", 32'(b.rd_busy[k]), 32'h1);
        chk("b_pend", 32'(b.pend_cnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port integer register file with a per-register pending-write scoreboard, for the pipelined core's decode stage.
- Provides NUM_RD combinational read ports and two prioritised write-back ports, with same-cycle write-to-read bypass.
- Tracks which registers have an issued-but-not-yet-written producer, so hazard logic can stall without duplicating register state.
- Supersedes the single-write, negedge-write register file: all state updates happen on the rising edge, and bypass covers the write/read half-cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data, combinational.
- rd_busy  out  NUM_RD  per-port flag: the addressed register has an outstanding producer.
- wr0_en, wr0_addr, wr0_data  in  1 / ADDR_WIDTH / DATA_WIDTH  write port 0 (ALU write-back).
- wr1_en, wr1_addr, wr1_data  in  1 / ADDR_WIDTH / DATA_WIDTH  write port 1 (load write-back).
- iss_en  in  1  a producer of iss_addr is issued this cycle.
- iss_addr  in  ADDR_WIDTH  destination register of the issued instruction.
- pend_cnt  out  ADDR_WIDTH+1  number of registers currently busy (registered).

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array plus a busy bit vector of the same depth.
- Write, on rising edge: enabled ports update the array.
  - If wr0_addr == wr1_addr with both enabled, port 1 wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Writes clear the busy bit of their address. A write to a register that is not busy is legal and leaves busy at 0.
- Issue: iss_en sets busy[iss_addr] at the edge.
  - If the same address is also written this cycle, set wins: a new producer overrides the completing one.
  - With ZERO_REG=1, issue to address 0 is ignored.
- Read data, per port, combinational, in priority order:
  - zero, if ZERO_REG=1 and addr==0;
  - otherwise wr1_data, if wr1 is enabled to the same address;
  - otherwise wr0_data, if wr0 is enabled to the same address;
  - otherwise the array contents.
- rd_busy: busy[addr] with any same-cycle write clear applied first.
  - A same-cycle issue is not visible until the next cycle.
  - Forced to 0 for address 0 when ZERO_REG=1.
- pend_cnt: incremented and decremented alongside busy-bit transitions; equals popcount(busy) at all times.
  - Net change per cycle is in the range -2..+1.
  - Never wraps, because it is bounded by depth.
- Reset: at the rising edge with rst=1, all array entries, all busy bits and pend_cnt go to 0.
  - rst has priority over any concurrent write or issue, which are discarded.
  - Reset in mid-operation drops all pending state; the pipeline is flushed concurrently.
- The array is not initialised by an initial block. Contents are undefined until the first reset.

## Timing
- Read latency is 0 cycles (combinational from address and write ports). Write latency is 1 edge, but the value is visible on the same cycle through bypass.
- Output values after reset: rd_data = 0 for every address, rd_busy = 0, pend_cnt = 0.
- Busy lifecycle: issue in cycle N gives rd_busy = 1 in cycle N+1. A write in cycle M gives rd_busy = 0 combinationally in cycle M and in the state from M+1 onward.
- There are no handshakes. Enables are single-cycle qualifiers, and there is no backpressure.
- Critical path: write-port address compare into the read mux. No registers sit on the read path.

## Structure
- Shared core package holds:
  - the REG_ZERO constant;
  - a localparam function for depth (2**ADDR_WIDTH);
  - a packed write-port struct type: en, addr, data.
- One sub-module is natural: rf_read_port (address compare, bypass mux, busy lookup), instantiated NUM_RD times in a generate loop.
- Array, busy vector and counter logic stay in the top level.

## Test plan
- Reset and zero register: assert rst, write 0xDEADBEEF to x0 and x5 in the same cycle. Then read x0 and x5, which must both return 0; pend_cnt must be 0.
- Bypass: with x7 = 0x11, in one cycle assert wr0 x7 = 0x22 and wr1 x7 = 0x33 while reading x7. rd_data must be 0x33 in that cycle and the array must hold 0x33 afterwards.
- Scoreboard: issue x3 in cycle 1, so rd_busy(x3) = 1 and pend_cnt = 1 in cycle 2. Write x3 in cycle 4, so rd_busy(x3) = 0 combinationally in cycle 4 and pend_cnt = 0 in cycle 5.
- Set-over-clear: x9 busy. In one cycle, issue x9 and write x9 = 0x5. Next cycle rd_busy(x9) = 1, rd_data = 0x5 and pend_cnt is unchanged.
- Counter extremes: issue all 31 nonzero registers, giving pend_cnt = 31. Then do a dual write of x1 and x2 in one cycle, giving pend_cnt = 29. Finally assert rst, giving pend_cnt = 0.
- Parameter sweep: NUM_RD = 4, ADDR_WIDTH = 4, ZERO_REG = 0. Write 0xA to x0, then all four ports read x0 = 0xA; issue x0 gives busy on all four ports.
